// File: rtl/twd_stage_ctrl.sv
// twd_stage_ctrl: frame sequencer and two-stage control pipeline for one FFT twiddle-multiply stage
module twd_stage_ctrl #(
  parameter int NBLK = 32,
  parameter int CNTW = $clog2(NBLK)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_valid,
  input  logic            i_sof,
  output logic            i_ready,
  output logic            s1_ld,
  output logic            mul_en,
  output logic [CNTW-1:0] mul_blk,
  output logic            s2_ld,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [CNTW-1:0] o_blk,
  output logic            o_sof,
  output logic            o_eof,
  output logic            frm_err,
  output logic [15:0]     frm_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNTW-1:0] LAST = CNTW'(NBLK - 1);

  state_t          state;
  logic [CNTW-1:0] blk_cnt;
  logic            s1_valid;
  logic            s1_sof;
  logic            s1_eof;
  logic            beat;
  logic            last;
  logic [CNTW-1:0] tag_blk;
  logic            tag_eof;

  // Handshake and tag for the block offered this cycle; a stray non-sof beat in IDLE is consumed but not loaded
  always_comb begin
    s2_ld   = s1_valid & (~o_valid | o_ready);
    i_ready = ~s1_valid | s2_ld;
    beat    = i_valid & i_ready;
    s1_ld   = beat & (i_sof | (state == RUN));
    last    = (blk_cnt == LAST);
    tag_blk = i_sof ? '0 : blk_cnt;
    tag_eof = ~i_sof & (state == RUN) & last;
  end

  assign mul_en  = s1_valid;

  // Frame tracker: counts blocks within a frame and flags framing violations (sticky)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      blk_cnt <= '0;
      frm_err <= 1'b0;
    end else if (beat) begin
      if (i_sof) begin
        state   <= RUN;
        blk_cnt <= CNTW'(1);
        if (state == RUN) frm_err <= 1'b1;
      end else if (state == IDLE) begin
        frm_err <= 1'b1;
      end else if (last) begin
        state   <= IDLE;
        blk_cnt <= '0;
      end else begin
        blk_cnt <= blk_cnt + CNTW'(1);
      end
    end
  end

  // S1: input register / multiplier stage, loaded on accept, emptied when it moves to S2
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      mul_blk  <= '0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
    end else if (s1_ld) begin
      s1_valid <= 1'b1;
      mul_blk  <= tag_blk;
      s1_sof   <= i_sof;
      s1_eof   <= tag_eof;
    end else if (s2_ld) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: output register, tag held stable until the downstream handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid <= 1'b0;
      o_blk   <= '0;
      o_sof   <= 1'b0;
      o_eof   <= 1'b0;
    end else if (s2_ld) begin
      o_valid <= 1'b1;
      o_blk   <= mul_blk;
      o_sof   <= s1_sof;
      o_eof   <= s1_eof;
    end else if (o_ready) begin
      o_valid <= 1'b0;
    end
  end

  // Completed-frame counter, bumped when the eof block leaves the stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) frm_cnt <= '0;
    else if (o_valid & o_ready & o_eof) frm_cnt <= frm_cnt + 16'd1;
  end

endmodule
